// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and the baud divisor helper.
// Used by uart_rx_param and uart_baud_tick.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BREAK
  } rx_state_e;

  // Rounded clock cycles per oversample tick; 0 flags an impossible configuration.
  function automatic int calc_div(input int clk_khz, input int baud, input int os);
    longint num;
    longint den;
    num = longint'(clk_khz) * longint'(1000);
    den = longint'(baud) * longint'(os);
    if (den <= 0) begin
      return 0;
    end
    return int'((num + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int INPUT_CLK_KHZ = 100_000,
  parameter int BAUD_RATE     = 115200,
  parameter int OVERSAMPLE    = 16
) (
  input  logic input_clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(INPUT_CLK_KHZ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: clock too slow for BAUD_RATE*OVERSAMPLE");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge input_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled mid-bit sampling and valid/ready output.
// Define UART_RX_MAJORITY_EN to resolve each bit by a 2-of-3 vote around mid-bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int INPUT_CLK_KHZ = 100_000,
  parameter int BAUD_RATE     = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                 input_clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TCW = $clog2(OVERSAMPLE + 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the tick after mid-bit, so every decision lands one tick later.
  localparam int START_AT = OVERSAMPLE / 2 + 1;
`else
  localparam int START_AT = OVERSAMPLE / 2;
`endif
  localparam logic [TCW-1:0] START_LAST = TCW'(START_AT - 1);
  localparam logic [TCW-1:0] BIT_LAST   = TCW'(OVERSAMPLE - 1);
  localparam logic [3:0]     DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST  = 4'(STOP_BITS - 1);
  localparam parity_e        PAR_MODE   = parity_e'(PARITY[1:0]);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
  end

  logic tick;

  uart_baud_tick #(
    .INPUT_CLK_KHZ(INPUT_CLK_KHZ),
    .BAUD_RATE    (BAUD_RATE),
    .OVERSAMPLE   (OVERSAMPLE)
  ) u_baud_tick (
    .input_clk(input_clk),
    .reset    (reset),
    .tick     (tick)
  );

  logic                 rx_meta_q;
  logic                 rx_sync_q;
  rx_state_e            state_q,       state_d;
  logic [TCW-1:0]       tick_cnt_q,    tick_cnt_d;
  logic [3:0]           bit_cnt_q,     bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,       shift_d;
  logic                 par_err_q,     par_err_d;
  logic                 frm_err_q,     frm_err_d;
  logic [DATA_BITS-1:0] data_out_q,    data_out_d;
  logic                 data_valid_q,  data_valid_d;
  logic                 parity_err_q,  parity_err_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 deliver;
  logic                 sample_now;
  logic                 bit_val;
  logic [TCW-1:0]       phase_last;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]           vote_q,        vote_d;
`endif

  assign phase_last = (state_q == START) ? START_LAST : BIT_LAST;
  assign sample_now = tick && (tick_cnt_q == phase_last) &&
                      (state_q != IDLE) && (state_q != BREAK);

`ifdef UART_RX_MAJORITY_EN
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync_q) | (vote_q[1] & rx_sync_q);
`else
  assign bit_val = rx_sync_q;
`endif

  always_ff @(posedge input_clk) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      frm_err_q     <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      vote_q        <= 2'b11;
`endif
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_err_q     <= par_err_d;
      frm_err_q     <= frm_err_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_MAJORITY_EN
      vote_q        <= vote_d;
`endif
    end
  end

  // Frame sequencing: tick_cnt restarts at every bit decision so decisions stay OVERSAMPLE apart.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    deliver    = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    vote_d     = vote_q;
    if (tick && tick_cnt_q == phase_last - TCW'(2)) begin
      vote_d[0] = rx_sync_q;
    end
    if (tick && tick_cnt_q == phase_last - TCW'(1)) begin
      vote_d[1] = rx_sync_q;
    end
`endif

    if (tick && state_q != IDLE && state_q != BREAK) begin
      tick_cnt_d = sample_now ? '0 : tick_cnt_q + TCW'(1);
    end

    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
      end
      START: begin
        if (sample_now) begin
          state_d = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample_now) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PAR_MODE != NONE) ? PAR : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (sample_now) begin
          par_err_d = (PAR_MODE == EVEN) ? (bit_val != ^shift_q) : (bit_val == ^shift_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (sample_now) begin
          frm_err_d = frm_err_q | ~bit_val;
          if (bit_cnt_q == STOP_LAST) begin
            deliver   = 1'b1;
            bit_cnt_d = '0;
            state_d   = bit_val ? IDLE : BREAK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rx_sync_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output handshake: a word arriving while the previous one is still unaccepted is dropped.
  always_comb begin
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overrun_err_d = 1'b0;

    if (data_valid_q && data_ready) begin
      data_valid_d  = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
    end

    if (deliver) begin
      if (data_valid_q && !data_ready) begin
        overrun_err_d = 1'b1;
      end else begin
        data_out_d    = shift_q;
        data_valid_d  = 1'b1;
        parity_err_d  = par_err_q;
        framing_err_d = frm_err_d;
      end
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != IDLE);

endmodule
